// File: rtl/psram_ctrl.sv
// PSRAM SPI command sequencer: power-up reset sequence, then single-byte read/write transactions.
// Latency: command byte strobes the cycle after acceptance; each byte waits for its spi_valid.
// Backpressure: ready is high only in IDLE; the byte engine paces via spi_valid with no timeout.
module psram_ctrl #(
  parameter int INIT_CYCLES = 20000,
  parameter int CE_GAP      = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [23:0] addr,
  input  logic [7:0]  wdata,
  output logic        ready,
  output logic [7:0]  rdata,
  output logic        rvalid,
  output logic        spi_strb,
  output logic [7:0]  spi_tx,
  input  logic [7:0]  spi_rx,
  input  logic        spi_valid,
  output logic        psram_ce_n
);

  // One counter serves both the power-up wait and the chip-select gaps.
  localparam int CNT_MAX = (INIT_CYCLES > CE_GAP) ? INIT_CYCLES : CE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(CE_GAP - 1);

  localparam logic [7:0] OP_RST_EN = 8'h66;
  localparam logic [7:0] OP_RST    = 8'h99;
  localparam logic [7:0] OP_WRITE  = 8'h02;
  localparam logic [7:0] OP_READ   = 8'h03;

  typedef enum logic [3:0] {
    INIT_WAIT = 4'd0,
    RST_EN    = 4'd1,
    GAP1      = 4'd2,
    RST       = 4'd3,
    GAP2      = 4'd4,
    IDLE      = 4'd5,
    CMD       = 4'd6,
    A2        = 4'd7,
    A1        = 4'd8,
    A0        = 4'd9,
    DATA      = 4'd10,
    END_GAP   = 4'd11
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             sent;       // strobe for the current byte has been issued
  logic             we_q;
  logic [23:0]      addr_q;
  logic [7:0]       wdata_q;

  logic             in_byte;    // a byte is owned by the engine, chip select asserted
  logic             byte_done;  // engine finished the byte we are waiting on
  logic             cnt_state;  // state measures its duration with cnt
  logic             cnt_last;

  // Byte states share one handshake: strobe on entry, leave on spi_valid after the strobe.
  assign in_byte = (state == RST_EN) || (state == RST) || (state == CMD) || (state == A2) ||
                   (state == A1) || (state == A0) || (state == DATA);

  // spi_valid is only meaningful once our strobe has gone out.
  assign byte_done = in_byte && sent && spi_valid;

  assign cnt_state = (state == INIT_WAIT) || (state == GAP1) || (state == GAP2) ||
                     (state == END_GAP);
  assign cnt_last  = (state == INIT_WAIT) ? (cnt == INIT_LAST) : (cnt == GAP_LAST);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= INIT_WAIT;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      INIT_WAIT: if (cnt_last)  state_nxt = RST_EN;
      RST_EN:    if (byte_done) state_nxt = GAP1;
      GAP1:      if (cnt_last)  state_nxt = RST;
      RST:       if (byte_done) state_nxt = GAP2;
      GAP2:      if (cnt_last)  state_nxt = IDLE;
      IDLE:      if (req)       state_nxt = CMD;
      CMD:       if (byte_done) state_nxt = A2;
      A2:        if (byte_done) state_nxt = A1;
      A1:        if (byte_done) state_nxt = A0;
      A0:        if (byte_done) state_nxt = DATA;
      DATA:      if (byte_done) state_nxt = END_GAP;
      END_GAP:   if (cnt_last)  state_nxt = IDLE;
      default:                  state_nxt = INIT_WAIT;
    endcase
  end

  // Duration counter and per-byte strobe tracking, both restart on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sent <= 1'b0;
    end else if (state_nxt != state) begin
      cnt  <= '0;
      sent <= 1'b0;
    end else begin
      cnt  <= cnt_state ? cnt + CNT_W'(1) : '0;
      sent <= in_byte;
    end
  end

  // Request capture on acceptance; held for the whole transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && req) begin
      we_q    <= we;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // Read data capture on the data byte completion; rvalid follows for exactly one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= (state == DATA) && byte_done && !we_q;
      if ((state == DATA) && byte_done && !we_q) begin
        rdata <= spi_rx;
      end
    end
  end

  // Outputs decoded from state; spi_tx is a pure function of state and latched request,
  // so it stays stable for the whole byte.
  always_comb begin
    ready      = (state == IDLE);
    psram_ce_n = !in_byte;
    spi_strb   = in_byte && !sent;
    spi_tx     = 8'h00;
    case (state)
      RST_EN:  spi_tx = OP_RST_EN;
      RST:     spi_tx = OP_RST;
      CMD:     spi_tx = we_q ? OP_WRITE : OP_READ;
      A2:      spi_tx = addr_q[23:16];
      A1:      spi_tx = addr_q[15:8];
      A0:      spi_tx = addr_q[7:0];
      DATA:    spi_tx = we_q ? wdata_q : 8'h00;
      default: spi_tx = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_psram_ctrl.sv
// Scoreboard bench for psram_ctrl: stimulus pushes expected bytes, read data and gaps;
// a negedge monitor pops and compares; a byte-engine model answers each strobe.
module tb_psram_ctrl;
  localparam int INIT_CYCLES = 8;
  localparam int CE_GAP      = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req;
  logic        we;
  logic [23:0] addr;
  logic [7:0]  wdata;
  logic        ready;
  logic [7:0]  rdata;
  logic        rvalid;
  logic        spi_strb;
  logic [7:0]  spi_tx;
  logic [7:0]  spi_rx;
  logic        spi_valid;
  logic        psram_ce_n;

  psram_ctrl #(.INIT_CYCLES(INIT_CYCLES), .CE_GAP(CE_GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ready(ready), .rdata(rdata), .rvalid(rvalid), .spi_strb(spi_strb), .spi_tx(spi_tx),
    .spi_rx(spi_rx), .spi_valid(spi_valid), .psram_ce_n(psram_ce_n)
  );

  initial forever #5 clk = ~clk;

  int         n_chk = 0;
  int         n_pass = 0;
  logic [7:0] exp_bytes[$];
  logic [7:0] exp_rd[$];
  int         exp_gap[$];
  int         strb_cnt = 0;
  int         eng_delay = 9;
  logic [7:0] rx_byte = 8'h00;
  int         spur_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Byte engine model: spi_valid eng_delay cycles after each strobe; 5th byte of a
  // chip-select period returns rx_byte, other bytes return junk.
  initial begin : engine
    int cd;
    int nbyte;
    int cur;
    int spur_seen;
    bit busy;
    cd = 0; nbyte = 0; cur = 0; spur_seen = 0; busy = 0;
    spi_valid = 1'b0;
    spi_rx    = 8'hA0;
    forever begin
      @(posedge clk);
      #1;
      spi_valid = 1'b0;
      spi_rx    = 8'hA0;
      if (!rst_n) begin
        busy  = 0;
        nbyte = 0;
      end else begin
        if (busy) begin
          cd--;
          if (cd <= 0) begin
            spi_valid = 1'b1;
            spi_rx    = (cur == 5) ? rx_byte : (8'hE0 | 8'(cur));
            busy      = 0;
          end
        end else if (spur_cnt != spur_seen) begin
          spi_valid = 1'b1;
          spi_rx    = 8'hBB;
          spur_seen++;
        end
        if (psram_ce_n) nbyte = 0;
        if (spi_strb) begin
          nbyte++;
          cur  = nbyte;
          busy = 1;
          cd   = eng_delay;
        end
      end
    end
  end

  // Monitor: compares strobed bytes, read returns, chip-select gaps and reset values.
  initial begin : monitor
    int         hi_run;
    bit         waiting;
    bit         stable;
    bit         prev_valid;
    bit         rst_checked;
    logic [7:0] hold_tx;
    hi_run = 0; waiting = 0; stable = 1; prev_valid = 0; rst_checked = 0; hold_tx = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hi_run     = 0;
        waiting    = 0;
        prev_valid = 0;
        if (!rst_checked) begin
          chk("rst_ce_n", psram_ce_n, 1);
          chk("rst_strb", spi_strb, 0);
          chk("rst_spi_tx", spi_tx, 8'h00);
          chk("rst_ready", ready, 0);
          chk("rst_rvalid", rvalid, 0);
          chk("rst_rdata", rdata, 8'h00);
          rst_checked = 1;
        end
      end else begin
        rst_checked = 0;
        if (psram_ce_n) begin
          hi_run++;
        end else begin
          if (hi_run > 0 && exp_gap.size() > 0) chk("ce_gap_len", hi_run, exp_gap.pop_front());
          hi_run = 0;
        end
        if (spi_strb) begin
          strb_cnt++;
          chk("strb_expected", exp_bytes.size() > 0, 1);
          if (exp_bytes.size() > 0) chk("strb_byte", spi_tx, exp_bytes.pop_front());
          chk("strb_ce_n", psram_ce_n, 0);
          hold_tx = spi_tx;
          waiting = 1;
          stable  = 1;
        end else if (waiting) begin
          if (spi_tx !== hold_tx || psram_ce_n !== 1'b0) stable = 0;
          if (spi_valid) begin
            chk("byte_hold_stable", stable, 1);
            waiting = 0;
          end
        end
        if (rvalid) begin
          chk("rvalid_expected", exp_rd.size() > 0, 1);
          if (exp_rd.size() > 0) chk("rdata", rdata, exp_rd.pop_front());
          chk("rvalid_after_data_valid", prev_valid, 1);
          chk("rvalid_ce_n", psram_ce_n, 1);
        end
        prev_valid = spi_valid;
      end
    end
  end

  // Release reset and expect the power-up wait, 0x66, gap, 0x99, gap, then ready.
  task automatic release_init();
    int n;
    exp_bytes.push_back(8'h66);
    exp_bytes.push_back(8'h99);
    exp_gap.push_back(INIT_CYCLES);
    exp_gap.push_back(CE_GAP);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    n = 0;
    while (!ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("init_cycles_to_ready", n, INIT_CYCLES + 2 * (9 + 1) + 2 * CE_GAP);
  endtask

  // One transaction from IDLE; called at a negedge. busy_exp = ready-low cycles.
  task automatic do_txn(input bit w, input logic [23:0] a, input logic [7:0] d,
                        input logic [7:0] rx, input int busy_exp);
    int n;
    exp_bytes.push_back(w ? 8'h02 : 8'h03);
    exp_bytes.push_back(a[23:16]);
    exp_bytes.push_back(a[15:8]);
    exp_bytes.push_back(a[7:0]);
    exp_bytes.push_back(w ? d : 8'h00);
    if (!w) exp_rd.push_back(rx);
    rx_byte = rx;
    we = w; addr = a; wdata = d; req = 1'b1;
    chk("idle_ready", ready, 1);
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (!ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("busy_cycles", n, busy_exp);
  endtask

  initial begin : stim
    int         n;
    int         target;
    bit         b2b_we[3];
    logic [23:0] b2b_addr[3];
    logic [7:0]  b2b_wdata[3];
    b2b_we[0] = 1; b2b_addr[0] = 24'h000001; b2b_wdata[0] = 8'h11;
    b2b_we[1] = 0; b2b_addr[1] = 24'h000002; b2b_wdata[1] = 8'h99;
    b2b_we[2] = 1; b2b_addr[2] = 24'hFFFFFF; b2b_wdata[2] = 8'hEE;

    rst_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    release_init();

    // Write, then read: 5 bytes of 10 cycles each plus the end gap.
    do_txn(1'b1, 24'h123456, 8'hA5, 8'h00, 5 * 10 + CE_GAP);
    do_txn(1'b0, 24'h00FF01, 8'h00, 8'h3C, 5 * 10 + CE_GAP);

    // Spurious spi_valid while idle must change nothing.
    spur_cnt++;
    repeat (4) @(negedge clk);
    chk("spur_ready", ready, 1);
    chk("spur_ce_n", psram_ce_n, 1);
    chk("rdata_hold", rdata, 8'h3C);

    // req held high: back-to-back transactions, gap = end gap plus the accepting idle cycle.
    rx_byte = 8'h77;
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      we = b2b_we[i]; addr = b2b_addr[i]; wdata = b2b_wdata[i];
      exp_bytes.push_back(b2b_we[i] ? 8'h02 : 8'h03);
      exp_bytes.push_back(b2b_addr[i][23:16]);
      exp_bytes.push_back(b2b_addr[i][15:8]);
      exp_bytes.push_back(b2b_addr[i][7:0]);
      exp_bytes.push_back(b2b_we[i] ? b2b_wdata[i] : 8'h00);
      if (!b2b_we[i]) exp_rd.push_back(8'h77);
      n = 0;
      while (!ready && n < 2000) begin
        n++;
        @(negedge clk);
      end
      chk("b2b_accept_in_time", n < 2000, 1);
      @(negedge clk);
      chk("b2b_busy", ready, 0);
      @(negedge clk);
      if (i < 2) exp_gap.push_back(CE_GAP + 1);
    end
    req = 1'b0;
    n = 0;
    while (!ready && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("b2b_all_bytes_seen", exp_bytes.size(), 0);
    chk("rdata_hold_after_write", rdata, 8'h77);

    // Slow byte engine: 40-cycle spi_valid delay on every byte.
    eng_delay = 40;
    do_txn(1'b0, 24'h0A0B0C, 8'h00, 8'hC3, 5 * 41 + CE_GAP);
    eng_delay = 9;

    // Reset during the A1 byte of a read: abort, no rvalid, init sequence reruns.
    exp_bytes.push_back(8'h03);
    exp_bytes.push_back(8'hAB);
    exp_bytes.push_back(8'hCD);
    target = strb_cnt + 3;
    we = 1'b0; addr = 24'hABCDEF; wdata = 8'h00; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    n = 0;
    while (strb_cnt < target && n < 500) begin
      n++;
      @(negedge clk);
    end
    chk("abort_reached_a1", strb_cnt >= target, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ce_n", psram_ce_n, 1);
    chk("async_strb", spi_strb, 0);
    chk("async_ready", ready, 0);
    repeat (3) @(negedge clk);
    release_init();

    do_txn(1'b1, 24'h555555, 8'h5A, 8'h00, 5 * 10 + CE_GAP);
    chk("rdata_after_reset", rdata, 8'h00);

    repeat (5) @(negedge clk);
    chk("exp_bytes_drained", exp_bytes.size(), 0);
    chk("exp_rd_drained", exp_rd.size(), 0);
    chk("exp_gap_drained", exp_gap.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run still active at 500000ns, expected completion earlier");
    $fatal(1, "watchdog expired");
  end

endmodule
